// File: rtl/round_key_store.sv
// Round-key buffer between the byte/word-serial key expansion and the cipher core.
// Captures NUM_ROUNDS+1 128-bit round keys from a valid/ready stream and replays
// them any number of times, forward (encrypt) or reverse (decrypt), MS lane first.
module round_key_store #(
  parameter int DATA_W     = 8,
  parameter int NUM_ROUNDS = 10,
  parameter int RND_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ks_valid,
  input  logic [DATA_W-1:0] ks_data,
  output logic              ks_ready,
  input  logic              mode,
  input  logic              rd_start,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [RND_W-1:0]  rd_round,
  output logic              rd_last,
  output logic              keys_ready,
  output logic              busy
);

  localparam int BEATS  = 128 / DATA_W;
  localparam int BEAT_W = $clog2(BEATS);

  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] PENULT_BEAT = BEAT_W'(BEATS - 2);
  localparam logic [BEAT_W-1:0] ZERO_BEAT   = {BEAT_W{1'b0}};
  localparam logic [BEAT_W-1:0] ONE_BEAT    = BEAT_W'(1);
  localparam logic [RND_W-1:0]  LAST_RND    = RND_W'(NUM_ROUNDS);
  localparam logic [RND_W-1:0]  FIRST_RND   = {RND_W{1'b0}};
  localparam logic [RND_W-1:0]  ONE_RND     = RND_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READY   = 2'd2,
    ST_STREAM  = 2'd3
  } state_t;

  state_t              state_r;
  logic [BEAT_W-1:0]   beat_cnt_r;
  logic [RND_W-1:0]    rnd_cnt_r;
  logic                mode_r;
  logic                rd_valid_r;
  logic                rd_last_r;
  logic                keys_ready_r;
  logic                busy_r;
  logic [RND_W-1:0]    rd_round_r;

  // One packed word of BEATS lanes per round key; lane BEATS-1 is the MS lane.
  logic [BEATS-1:0][DATA_W-1:0] key_mem_r [0:NUM_ROUNDS];

  logic [BEAT_W-1:0]   lane_s;
  logic                ks_fire_s;
  logic [RND_W-1:0]    end_rnd_s;
  logic [RND_W-1:0]    step_rnd_s;

  // Beat 0 of a key maps to its most significant lane.
  assign lane_s     = LAST_BEAT - beat_cnt_r;
  assign ks_ready   = (state_r == ST_CAPTURE);
  // A beat coinciding with start is dropped: start restarts the capture instead.
  assign ks_fire_s  = ks_ready && ks_valid && !start;
  // Round that carries the final beat of a replay, and the next round to visit.
  assign end_rnd_s  = mode_r ? FIRST_RND : LAST_RND;
  assign step_rnd_s = mode_r ? (rnd_cnt_r - ONE_RND) : (rnd_cnt_r + ONE_RND);

  // Counters are frozen during a stall, so the replayed lane is stable until accepted.
  assign rd_data    = (state_r == ST_STREAM) ? key_mem_r[rnd_cnt_r][lane_s] : {DATA_W{1'b0}};

  assign rd_valid   = rd_valid_r;
  assign rd_last    = rd_last_r;
  assign rd_round   = rd_round_r;
  assign keys_ready = keys_ready_r;
  assign busy       = busy_r;

  // Key register file: one lane written per accepted key-schedule beat (no reset).
  always_ff @(posedge clk) begin
    if (ks_fire_s) begin
      key_mem_r[rnd_cnt_r][lane_s] <= ks_data;
    end
  end

  // Control FSM with counters and registered status/stream outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      beat_cnt_r   <= ZERO_BEAT;
      rnd_cnt_r    <= FIRST_RND;
      mode_r       <= 1'b0;
      rd_valid_r   <= 1'b0;
      rd_last_r    <= 1'b0;
      keys_ready_r <= 1'b0;
      busy_r       <= 1'b0;
      rd_round_r   <= FIRST_RND;
    end else if (start) begin
      // Abort whatever is in progress and capture a fresh key set.
      state_r      <= ST_CAPTURE;
      beat_cnt_r   <= ZERO_BEAT;
      rnd_cnt_r    <= FIRST_RND;
      rd_valid_r   <= 1'b0;
      rd_last_r    <= 1'b0;
      keys_ready_r <= 1'b0;
      busy_r       <= 1'b1;
      rd_round_r   <= FIRST_RND;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_IDLE;
        end

        ST_CAPTURE: begin
          if (ks_valid) begin
            if (beat_cnt_r == LAST_BEAT) begin
              beat_cnt_r <= ZERO_BEAT;
              if (rnd_cnt_r == LAST_RND) begin
                state_r      <= ST_READY;
                rnd_cnt_r    <= FIRST_RND;
                keys_ready_r <= 1'b1;
                busy_r       <= 1'b0;
              end else begin
                rnd_cnt_r <= rnd_cnt_r + ONE_RND;
              end
            end else begin
              beat_cnt_r <= beat_cnt_r + ONE_BEAT;
            end
          end
        end

        ST_READY: begin
          if (rd_start) begin
            state_r    <= ST_STREAM;
            mode_r     <= mode;
            beat_cnt_r <= ZERO_BEAT;
            rnd_cnt_r  <= mode ? LAST_RND : FIRST_RND;
            rd_round_r <= mode ? LAST_RND : FIRST_RND;
            rd_valid_r <= 1'b1;
            rd_last_r  <= 1'b0;
            busy_r     <= 1'b1;
          end
        end

        ST_STREAM: begin
          if (rd_ready) begin
            if (beat_cnt_r == LAST_BEAT) begin
              beat_cnt_r <= ZERO_BEAT;
              if (rnd_cnt_r == end_rnd_s) begin
                // Final beat accepted: keys stay valid for another replay.
                state_r    <= ST_READY;
                rnd_cnt_r  <= FIRST_RND;
                rd_round_r <= FIRST_RND;
                rd_valid_r <= 1'b0;
                rd_last_r  <= 1'b0;
                busy_r     <= 1'b0;
              end else begin
                rnd_cnt_r  <= step_rnd_s;
                rd_round_r <= step_rnd_s;
                rd_last_r  <= 1'b0;
              end
            end else begin
              beat_cnt_r <= beat_cnt_r + ONE_BEAT;
              rd_last_r  <= (beat_cnt_r == PENULT_BEAT) && (rnd_cnt_r == end_rnd_s);
            end
          end
        end

        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_round_key_store.sv
// Directed bench for round_key_store: an 8-bit/10-round and a 32-bit/14-round
// instance, table-driven replays plus hand-written abort and reset sequences.
module tb_round_key_store;

  logic clk;
  logic rst;

  logic        start8, ks_valid8, ks_ready8, mode8, rd_start8, rd_valid8, rd_ready8;
  logic [7:0]  ks_data8, rd_data8;
  logic [3:0]  rd_round8;
  logic        rd_last8, keys_ready8, busy8;

  logic        start32, ks_valid32, ks_ready32, mode32, rd_start32, rd_valid32, rd_ready32;
  logic [31:0] ks_data32, rd_data32;
  logic [3:0]  rd_round32;
  logic        rd_last32, keys_ready32, busy32;

  int checks = 0;
  int errors = 0;

  bit          tb_sel;
  logic        obs_valid, obs_last, obs_keys_ready, obs_busy, obs_ks_ready;
  logic [31:0] obs_data;
  logic [3:0]  obs_round;

  round_key_store #(.DATA_W(8), .NUM_ROUNDS(10), .RND_W(4)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .ks_valid(ks_valid8), .ks_data(ks_data8),
    .ks_ready(ks_ready8), .mode(mode8), .rd_start(rd_start8), .rd_valid(rd_valid8),
    .rd_ready(rd_ready8), .rd_data(rd_data8), .rd_round(rd_round8), .rd_last(rd_last8),
    .keys_ready(keys_ready8), .busy(busy8)
  );

  round_key_store #(.DATA_W(32), .NUM_ROUNDS(14), .RND_W(4)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .ks_valid(ks_valid32), .ks_data(ks_data32),
    .ks_ready(ks_ready32), .mode(mode32), .rd_start(rd_start32), .rd_valid(rd_valid32),
    .rd_ready(rd_ready32), .rd_data(rd_data32), .rd_round(rd_round32), .rd_last(rd_last32),
    .keys_ready(keys_ready32), .busy(busy32)
  );

  assign obs_valid      = tb_sel ? rd_valid32   : rd_valid8;
  assign obs_last       = tb_sel ? rd_last32    : rd_last8;
  assign obs_keys_ready = tb_sel ? keys_ready32 : keys_ready8;
  assign obs_busy       = tb_sel ? busy32       : busy8;
  assign obs_ks_ready   = tb_sel ? ks_ready32   : ks_ready8;
  assign obs_data       = tb_sel ? rd_data32    : {24'd0, rd_data8};
  assign obs_round      = tb_sel ? rd_round32   : rd_round8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sel;
    bit          mode;
    bit          stall;
    logic [31:0] f_data;
    logic [3:0]  f_rnd;
    logic [31:0] l_data;
    logic [3:0]  l_rnd;
    int          cycles;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load data: byte index for the 8-bit lane, four consecutive byte indices per word.
  function automatic logic [31:0] load_data(input bit sel, input int idx);
    int b;
    if (sel) begin
      b = 4 * idx;
      load_data = 32'((b << 24) | ((b + 1) << 16) | ((b + 2) << 8) | (b + 3));
    end else begin
      load_data = 32'(idx % 256);
    end
  endfunction

  function automatic logic [3:0] exp_round(input bit sel, input bit m, input int p);
    int nb, nr;
    nb = sel ? 4 : 16;
    nr = sel ? 14 : 10;
    exp_round = 4'(m ? (nr - p / nb) : (p / nb));
  endfunction

  function automatic logic [31:0] exp_data(input bit sel, input bit m, input int p);
    int nb;
    nb = sel ? 4 : 16;
    exp_data = load_data(sel, int'(exp_round(sel, m, p)) * nb + (p % nb));
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) start32 = v; else start8 = v;
  endtask

  task automatic load(input bit sel, input bit gaps, input bit do_start);
    int total, idx, cyc;
    logic v;
    logic [31:0] d;
    tb_sel = sel;
    total  = sel ? 60 : 176;
    if (do_start) begin
      set_start(sel, 1'b1);
      tick();
      set_start(sel, 1'b0);
      chk("ks_ready in capture", obs_ks_ready, 1);
    end
    idx = 0;
    cyc = 0;
    while (idx < total && cyc < 2000) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      d = v ? load_data(sel, idx) : 32'hDEADBEEF;
      if (sel) begin ks_valid32 = v; ks_data32 = d; end
      else     begin ks_valid8  = v; ks_data8  = d[7:0]; end
      if (v && idx == total - 1) chk("keys_ready before last beat", obs_keys_ready, 0);
      tick();
      if (v) idx++;
      cyc++;
    end
    ks_valid8  = 1'b0;
    ks_valid32 = 1'b0;
    chk("load beat count", idx, total);
    chk("keys_ready after load", obs_keys_ready, 1);
    chk("ks_ready after load", obs_ks_ready, 0);
    chk("busy after load", obs_busy, 0);
  endtask

  task automatic replay(input vec_t v);
    int total, p, cyc;
    logic rdy;
    logic [31:0] f_d, l_d;
    logic [3:0]  f_r, l_r;
    tb_sel = v.sel;
    total  = v.sel ? 60 : 176;
    f_d = 32'hFFFFFFFF; l_d = 32'hFFFFFFFF;
    f_r = 4'hF;         l_r = 4'hF;
    if (v.sel) begin mode32 = v.mode; rd_start32 = 1'b1; end
    else       begin mode8  = v.mode; rd_start8  = 1'b1; end
    tick();
    rd_start8  = 1'b0;
    rd_start32 = 1'b0;
    chk("rd_valid one cycle after rd_start", obs_valid, 1);
    p   = 0;
    cyc = 0;
    while (p < total && cyc < 1000) begin
      rdy = v.stall ? (cyc % 2 == 1) : 1'b1;
      if (v.sel) rd_ready32 = rdy; else rd_ready8 = rdy;
      chk("replay beat {valid,last,round,data}",
          {obs_valid, obs_last, obs_round, obs_data},
          {1'b1, (p == total - 1), exp_round(v.sel, v.mode, p), exp_data(v.sel, v.mode, p)});
      if (cyc == 0) begin f_d = obs_data; f_r = obs_round; end
      if (obs_last) begin l_d = obs_data; l_r = obs_round; end
      tick();
      if (rdy) p++;
      cyc++;
    end
    rd_ready8  = 1'b0;
    rd_ready32 = 1'b0;
    chk("replay cycles", cyc, v.cycles);
    chk("first beat data", f_d, v.f_data);
    chk("first beat round", f_r, v.f_rnd);
    chk("last beat data", l_d, v.l_data);
    chk("last beat round", l_r, v.l_rnd);
    chk("rd_valid after last", obs_valid, 0);
    chk("keys_ready after replay", obs_keys_ready, 1);
    chk("busy after replay", obs_busy, 0);
  endtask

  initial begin
    vecs[0] = '{sel: 1'b0, mode: 1'b0, stall: 1'b0, f_data: 32'h00, f_rnd: 4'd0,
                l_data: 32'hAF, l_rnd: 4'd10, cycles: 176};
    vecs[1] = '{sel: 1'b0, mode: 1'b1, stall: 1'b1, f_data: 32'hA0, f_rnd: 4'd10,
                l_data: 32'h0F, l_rnd: 4'd0, cycles: 352};
    vecs[2] = '{sel: 1'b0, mode: 1'b0, stall: 1'b1, f_data: 32'h00, f_rnd: 4'd0,
                l_data: 32'hAF, l_rnd: 4'd10, cycles: 352};
    vecs[3] = '{sel: 1'b0, mode: 1'b1, stall: 1'b0, f_data: 32'hA0, f_rnd: 4'd10,
                l_data: 32'h0F, l_rnd: 4'd0, cycles: 176};
    vecs[4] = '{sel: 1'b1, mode: 1'b0, stall: 1'b0, f_data: 32'h00010203, f_rnd: 4'd0,
                l_data: 32'hECEDEEEF, l_rnd: 4'd14, cycles: 60};
    vecs[5] = '{sel: 1'b1, mode: 1'b1, stall: 1'b1, f_data: 32'hE0E1E2E3, f_rnd: 4'd14,
                l_data: 32'h0C0D0E0F, l_rnd: 4'd0, cycles: 120};

    rst = 1'b0;
    start8 = 1'b0; ks_valid8 = 1'b0; ks_data8 = 8'd0; mode8 = 1'b0; rd_start8 = 1'b0; rd_ready8 = 1'b0;
    start32 = 1'b0; ks_valid32 = 1'b0; ks_data32 = 32'd0; mode32 = 1'b0; rd_start32 = 1'b0; rd_ready32 = 1'b0;
    tb_sel = 1'b0;

    // Reset state
    #3;
    chk("reset rd_valid", rd_valid8, 0);
    chk("reset rd_last", rd_last8, 0);
    chk("reset keys_ready", keys_ready8, 0);
    chk("reset busy", busy8, 0);
    chk("reset ks_ready", ks_ready8, 0);
    chk("reset rd_data", rd_data8, 0);
    chk("reset rd_round", rd_round8, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // rd_start in IDLE is ignored
    rd_start8 = 1'b1;
    tick();
    rd_start8 = 1'b0;
    chk("rd_start in IDLE: rd_valid", rd_valid8, 0);
    chk("rd_start in IDLE: busy", busy8, 0);

    // Enter capture, rd_start in CAPTURE is ignored, ks_valid=0 stalls
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("capture busy", busy8, 1);
    chk("capture ks_ready", ks_ready8, 1);
    rd_start8 = 1'b1;
    tick();
    rd_start8 = 1'b0;
    tick();
    chk("rd_start in CAPTURE: rd_valid", rd_valid8, 0);
    chk("rd_start in CAPTURE: ks_ready", ks_ready8, 1);

    // Abort capture at beat 50; the beat presented with start is dropped
    for (int i = 0; i < 50; i++) begin
      ks_valid8 = 1'b1;
      ks_data8  = 8'(i);
      tick();
    end
    start8 = 1'b1; ks_valid8 = 1'b1; ks_data8 = 8'hEE;
    tick();
    start8 = 1'b0; ks_valid8 = 1'b0;
    chk("abort capture keys_ready", keys_ready8, 0);
    chk("abort capture rd_valid", rd_valid8, 0);
    chk("abort capture busy", busy8, 1);
    chk("abort capture ks_ready", ks_ready8, 1);
    load(1'b0, 1'b0, 1'b0);

    // 32-bit / 14-round instance with random valid gaps
    load(1'b1, 1'b1, 1'b1);

    // Table-driven replays
    for (int i = 0; i < 6; i++) begin
      replay(vecs[i]);
    end

    // Abort a stream at beat 30, reload, replay again
    tb_sel = 1'b0;
    mode8 = 1'b0; rd_start8 = 1'b1;
    tick();
    rd_start8 = 1'b0;
    rd_ready8 = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("mid-stream data at beat 30", rd_data8, exp_data(1'b0, 1'b0, 30));
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    rd_ready8 = 1'b0;
    chk("abort stream keys_ready", keys_ready8, 0);
    chk("abort stream rd_valid", rd_valid8, 0);
    chk("abort stream rd_last", rd_last8, 0);
    chk("abort stream ks_ready", ks_ready8, 1);
    load(1'b0, 1'b0, 1'b0);
    replay(vecs[0]);

    // start and rd_start in the same cycle: capture wins
    start8 = 1'b1; rd_start8 = 1'b1;
    tick();
    start8 = 1'b0; rd_start8 = 1'b0;
    chk("start+rd_start busy", busy8, 1);
    chk("start+rd_start ks_ready", ks_ready8, 1);
    chk("start+rd_start keys_ready", keys_ready8, 0);
    chk("start+rd_start rd_valid", rd_valid8, 0);
    tick();
    chk("start+rd_start rd_valid later", rd_valid8, 0);

    // Asynchronous reset mid-stream on the 32-bit instance
    tb_sel = 1'b1;
    mode32 = 1'b0; rd_start32 = 1'b1;
    tick();
    rd_start32 = 1'b0;
    rd_ready32 = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("pre-reset rd_valid", rd_valid32, 1);
    chk("pre-reset rd_data", rd_data32, exp_data(1'b1, 1'b0, 5));
    #2;
    rst = 1'b0;
    #1;
    chk("async reset rd_valid", rd_valid32, 0);
    chk("async reset rd_last", rd_last32, 0);
    chk("async reset keys_ready", keys_ready32, 0);
    chk("async reset busy", busy32, 0);
    chk("async reset ks_ready", ks_ready32, 0);
    chk("async reset rd_data", rd_data32, 0);
    chk("async reset rd_round", rd_round32, 0);
    rd_ready32 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_key_store.md
Name: round_key_store

Overview:
- Parametrised buffer that sits between the byte-serial key-expansion datapath and the encrypt/decrypt core.
- It captures the serial round-key stream into a register file holding NUM_ROUNDS+1 round keys of 128 bits each.
- It replays the keys to the cipher core over a valid/ready stream, in forward order for encryption or reverse order for decryption.
- It replaces the ad-hoc counter-timed key capture with an explicit handshake, supports variable lane width and round count, and supports repeated replay without re-expansion.

Parameters:
DATA_W, 8, lane width in bits; legal values 8, 32; BEATS = 128/DATA_W beats per round key
NUM_ROUNDS, 10, cipher rounds; legal values 10, 12, 14; NUM_ROUNDS+1 keys stored
RND_W, 4, width of round index outputs

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  pulse: discard stored keys, begin new capture
ks_valid  in  1  key-schedule beat valid
ks_data  in  DATA_W  key-schedule beat, most significant lane of round key first
ks_ready  out  1  store accepts a beat
mode  in  1  0 = encrypt order (round 0..NR), 1 = decrypt order (NR..0); sampled on accepted rd_start
rd_start  in  1  pulse: begin one replay of all NUM_ROUNDS+1 keys
rd_valid  out  1  rd_data valid
rd_ready  in  1  consumer accepts beat
rd_data  out  DATA_W  replayed round-key beat, MS lane first
rd_round  out  RND_W  round index of the current rd_data beat
rd_last  out  1  final beat of the final key of the replay
keys_ready  out  1  full key set held and valid
busy  out  1  state is CAPTURE or STREAM

Behaviour:
- States: IDLE, CAPTURE, READY, STREAM. Two counters:
  - beat_cnt: 0..BEATS-1
  - rnd_cnt: 0..NUM_ROUNDS
- Reset (rst=0, asynchronous):
  - state=IDLE; all counters 0.
  - ks_ready, rd_valid, rd_last, keys_ready, busy all 0; rd_data=0; rd_round=0.
  - Register-file contents are not cleared.
- IDLE: start -> CAPTURE with counters cleared. rd_start is ignored.
- CAPTURE:
  - ks_ready=1 combinationally.
  - Each cycle with ks_valid&&ks_ready writes ks_data into key[rnd_cnt], lane (BEATS-1-beat_cnt), and increments beat_cnt.
  - beat_cnt wraps to 0 after BEATS-1 and increments rnd_cnt.
  - The beat with beat_cnt=BEATS-1 and rnd_cnt=NUM_ROUNDS -> READY; keys_ready=1 from the next cycle.
  - ks_valid=0 stalls without any state change.
- READY:
  - keys_ready=1, ks_ready=0.
  - rd_start latches mode, sets rnd_cnt = 0 (enc) or NUM_ROUNDS (dec), beat_cnt=0, and goes to STREAM.
  - rd_valid rises the cycle after rd_start (latency 1).
- STREAM:
  - rd_valid=1. rd_data = lane (BEATS-1-beat_cnt) of key[rnd_cnt]. rd_round = rnd_cnt.
  - rd_data, rd_round and rd_last stay stable while rd_valid && !rd_ready.
  - On a handshake, beat_cnt advances. At wrap, rnd_cnt increments (enc) or decrements (dec).
  - rd_last=1 on beat BEATS-1 of round NUM_ROUNDS (enc) or of round 0 (dec).
  - The handshake on rd_last returns to READY; rd_valid=0 next cycle. keys_ready stays 1 throughout, so keys remain replayable.
- start in any non-reset state:
  - Aborts the current operation: keys_ready=0, rd_valid=0 and rd_last=0 next cycle, then CAPTURE.
  - start wins over a simultaneous rd_start or handshake.
  - A beat presented in the same cycle as start is not written.
- rd_start outside READY is ignored; no error is flagged.
- ks_valid outside CAPTURE is ignored (ks_ready=0); the beat is neither stored nor counted.
- Counters never exceed their range; rnd_cnt in dec mode never underflows past 0.
- Single clock domain. All outputs are registered except ks_ready and rd_data; rd_data is a mux from registered state.

Test Plan:
- Reset then start, DATA_W=8, NUM_ROUNDS=10: stream 176 bytes with ks_data = byte index mod 256, ks_valid always 1 -> keys_ready rises the cycle after beat 175; ks_ready=0 afterwards.
- Encrypt replay: rd_start, mode=0, rd_ready=1 -> first beat (rd_data=0x00, rd_round=0) one cycle after rd_start; 176 consecutive beats; rd_last only with rd_data=0xAF, rd_round=10; then READY.
- Decrypt replay with rd_ready toggling 1/0 every cycle:
  - First beat is rd_round=10, rd_data=0xA0.
  - Data holds stable across each stall.
  - rd_last arrives with rd_round=0, rd_data=0x0F after 352 cycles.
- start asserted mid-capture (beat 50) and again mid-stream (beat 30):
  - keys_ready=0 and rd_valid=0 the next cycle.
  - Capture restarts at round 0 lane 15.
  - A fresh 176-byte load produces correct replay.
- DATA_W=32, NUM_ROUNDS=14: 60 words with random ks_valid gaps -> keys_ready after word 59; encrypt replay gives 60 beats, rd_last on rd_round=14 beat 3.
- Boundary cases:
  - rd_start in IDLE or CAPTURE: no rd_valid.
  - Assert rst=0 asynchronously mid-stream: all outputs 0 immediately, without a clock edge.
  - start and rd_start in the same cycle: CAPTURE entered, no stream.
